// File: rtl/controlador_bus.sv
// Round-robin register-to-register transfer sequencer for the shared 8-bit bus.
// Optional CONTROLADOR_BUS_SKIPSELF_EN: src == dst transfers skip DRIVE/LATCH.
module controlador_bus #(
  parameter int unsigned NREG = 4,
  parameter int unsigned NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] src,
  input  logic [2*NREQ-1:0] dst,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [NREG-1:0]   load,
  output logic [NREG-1:0]   save,
  output logic              busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PtrW-1:0] PtrRst = PtrW'(NREQ - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StLatch = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [1:0]      src_q, src_d;
  logic [1:0]      dst_q, dst_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREG-1:0] load_q, load_d;
  logic [NREG-1:0] save_q, save_d;
  logic            busy_q, busy_d;

  logic            found;
  logic [PtrW-1:0] win;
  logic [PtrW-1:0] cand;
  logic [1:0]      win_src;
  logic [1:0]      win_dst;

  // Indices at or above NREG match no bit, so the enable stays all-zero.
  function automatic logic [NREG-1:0] dec(input logic [1:0] idx);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      oh[r] = (idx == 2'(r));
    end
    return oh;
  endfunction

  // Priority starts one past the last winner and wraps.
  always_comb begin
    found   = 1'b0;
    win     = ptr_q;
    cand    = ptr_q;
    win_src = '0;
    win_dst = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (win == PtrW'(j)) begin
        win_src = src[2*j +: 2];
        win_dst = dst[2*j +: 2];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    dst_d   = dst_q;
    grant_d = '0;
    done_d  = '0;
    load_d  = '0;
    save_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          ptr_d          = win;
          src_d          = win_src;
          dst_d          = win_dst;
          grant_d[win]   = 1'b1;
`ifdef CONTROLADOR_BUS_SKIPSELF_EN
          if (win_src == win_dst) begin
            state_d     = StDone;
            done_d[win] = 1'b1;
          end else begin
            state_d = StDrive;
            load_d  = dec(win_src);
          end
`else
          state_d = StDrive;
          load_d  = dec(win_src);
`endif
        end
      end
      StDrive: begin
        state_d = StLatch;
        load_d  = dec(src_q);
        save_d  = dec(dst_q);
      end
      StLatch: begin
        state_d       = StDone;
        done_d[ptr_q] = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= PtrRst;
      src_q   <= '0;
      dst_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      load_q  <= '0;
      save_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      load_q  <= load_d;
      save_q  <= save_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign load  = load_q;
  assign save  = save_q;
  assign busy  = busy_q;

endmodule
